// File: rtl/deck_dealer.sv
`default_nettype none
// ============================================================================
//  Module      : deck_dealer
//  Description : 52-card shoe and hand-sum engine for the blackjack game.
//                Fills the deck, Fisher-Yates shuffles it using a 16-bit
//                Galois LFSR, deals one card per draw request and keeps the
//                high/low totals of the player 1, player 2 and dealer hands.
//  Ports       : clk, rst_n          clock, async active-low reset
//                new_game           pulse: clear hands, refill, reshuffle
//                draw_sel[1:0]      level request (0 none, 1 P1, 2 P2, 3 D)
//                p1/p2/d_high/low   5-bit hand totals (saturate at 31)
//                cards_updated      one-cycle pulse after each deal
//                busy               high while filling or shuffling
//                last_card[5:0]     {suit, rank} of the last dealt card
//                cards_remaining    undealt cards, 0 while busy
//  Revision    : 1.0  initial release
// ============================================================================
module deck_dealer #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       new_game,
    input  logic [1:0] draw_sel,
    output logic [4:0] p1_high,
    output logic [4:0] p1_low,
    output logic [4:0] p2_high,
    output logic [4:0] p2_low,
    output logic [4:0] d_high,
    output logic [4:0] d_low,
    output logic       cards_updated,
    output logic       busy,
    output logic [5:0] last_card,
    output logic [5:0] cards_remaining
);

    localparam logic [15:0] c_LFSR_INIT = (LFSR_SEED == 16'd0) ? 16'hACE1 : LFSR_SEED;
    localparam logic [15:0] c_LFSR_POLY = 16'hB400;
    localparam logic [5:0]  c_DECK_SIZE = 6'd52;
    localparam logic [5:0]  c_LAST_IDX  = 6'd51;

    typedef enum logic [2:0] {
        S_FILL         = 3'd0,
        S_SHUFFLE      = 3'd1,
        S_READY        = 3'd2,
        S_DEAL         = 3'd3,
        S_WAIT_RELEASE = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [5:0]  r_deck [0:51];
    logic [5:0]  r_fill_idx;
    logic [1:0]  r_fill_suit;
    logic [3:0]  r_fill_rank;
    logic [5:0]  r_shuf_i;
    logic [5:0]  r_ptr;
    logic [15:0] r_lfsr;
    logic [1:0]  r_target;
    logic [4:0]  r_low [0:2];
    logic        r_ace [0:2];
    logic [5:0]  r_last_card;
    logic        r_cards_updated;

    logic [5:0]  w_mask;
    logic [5:0]  w_j;
    logic        w_accept;
    logic [5:0]  w_card;
    logic [3:0]  w_value;

    function automatic logic [4:0] sat5(input logic [5:0] s);
        return (s > 6'd31) ? 5'd31 : s[4:0];
    endfunction

    function automatic logic [4:0] high_of(input logic [4:0] low, input logic ace);
        return sat5({1'b0, low} + (ace ? 6'd10 : 6'd0));
    endfunction

    // Smallest 2^k-1 covering the shuffle index, so that the masked LFSR
    // candidate is accepted with at least 50% probability.
    always_comb begin
        w_mask = 6'd63;
        if (r_shuf_i <= 6'd1)       w_mask = 6'd1;
        else if (r_shuf_i <= 6'd3)  w_mask = 6'd3;
        else if (r_shuf_i <= 6'd7)  w_mask = 6'd7;
        else if (r_shuf_i <= 6'd15) w_mask = 6'd15;
        else if (r_shuf_i <= 6'd31) w_mask = 6'd31;
    end

    assign w_j      = r_lfsr[5:0] & w_mask;
    assign w_accept = (w_j <= r_shuf_i);
    assign w_card   = r_deck[r_ptr];
    // Face cards count 10; ace counts 1 in the low total.
    assign w_value  = (w_card[3:0] >= 4'd10) ? 4'd10 : w_card[3:0];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FILL;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FILL:         if (r_fill_idx == c_LAST_IDX) w_next_state = S_SHUFFLE;
            S_SHUFFLE:      if (w_accept && r_shuf_i == 6'd1) w_next_state = S_READY;
            S_READY: begin
                if (draw_sel != 2'd0) begin
                    // Empty shoe: refill and reshuffle, then serve the
                    // still-held request from READY.
                    if (r_ptr == c_DECK_SIZE) w_next_state = S_FILL;
                    else                      w_next_state = S_DEAL;
                end
            end
            S_DEAL:         w_next_state = S_WAIT_RELEASE;
            S_WAIT_RELEASE: if (draw_sel == 2'd0) w_next_state = S_READY;
            default:        w_next_state = S_FILL;
        endcase
        if (new_game) w_next_state = S_FILL;
    end

    // ------------------------------------------------------------------
    // Control / hand datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr          <= c_LFSR_INIT;
            r_fill_idx      <= 6'd0;
            r_fill_suit     <= 2'd0;
            r_fill_rank     <= 4'd1;
            r_shuf_i        <= c_LAST_IDX;
            r_ptr           <= 6'd0;
            r_target        <= 2'd0;
            r_last_card     <= 6'd0;
            r_cards_updated <= 1'b0;
            for (int h = 0; h < 3; h++) begin
                r_low[h] <= 5'd0;
                r_ace[h] <= 1'b0;
            end
        end else begin
            // Free-running so the user's timing seeds each shuffle.
            r_lfsr          <= (r_lfsr >> 1) ^ (r_lfsr[0] ? c_LFSR_POLY : 16'd0);
            r_cards_updated <= 1'b0;
            if (new_game) begin
                r_fill_idx  <= 6'd0;
                r_fill_suit <= 2'd0;
                r_fill_rank <= 4'd1;
                r_last_card <= 6'd0;
                for (int h = 0; h < 3; h++) begin
                    r_low[h] <= 5'd0;
                    r_ace[h] <= 1'b0;
                end
            end else begin
                case (r_state)
                    S_FILL: begin
                        if (r_fill_idx == c_LAST_IDX) begin
                            // Counters rewound here so a later refill
                            // starts clean.
                            r_fill_idx  <= 6'd0;
                            r_fill_suit <= 2'd0;
                            r_fill_rank <= 4'd1;
                            r_shuf_i    <= c_LAST_IDX;
                        end else begin
                            r_fill_idx <= r_fill_idx + 6'd1;
                            if (r_fill_rank == 4'd13) begin
                                r_fill_rank <= 4'd1;
                                r_fill_suit <= r_fill_suit + 2'd1;
                            end else begin
                                r_fill_rank <= r_fill_rank + 4'd1;
                            end
                        end
                    end
                    S_SHUFFLE: begin
                        if (w_accept) begin
                            if (r_shuf_i == 6'd1) r_ptr <= 6'd0;
                            else                  r_shuf_i <= r_shuf_i - 6'd1;
                        end
                    end
                    S_READY: begin
                        if (draw_sel != 2'd0 && r_ptr != c_DECK_SIZE) r_target <= draw_sel;
                    end
                    S_DEAL: begin
                        for (int h = 0; h < 3; h++) begin
                            if (r_target == 2'(h + 1)) begin
                                r_low[h] <= sat5({1'b0, r_low[h]} + {2'b00, w_value});
                                if (w_card[3:0] == 4'd1) r_ace[h] <= 1'b1;
                            end
                        end
                        r_last_card     <= w_card;
                        r_ptr           <= r_ptr + 6'd1;
                        r_cards_updated <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Deck storage carries no reset: every entry is rewritten by FILL
    // before it can be read.
    always_ff @(posedge clk) begin
        if (r_state == S_FILL) begin
            r_deck[r_fill_idx] <= {r_fill_suit, r_fill_rank};
        end else if (r_state == S_SHUFFLE && w_accept) begin
            r_deck[r_shuf_i] <= r_deck[w_j];
            r_deck[w_j]      <= r_deck[r_shuf_i];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy            = (r_state == S_FILL) || (r_state == S_SHUFFLE);
    assign cards_remaining = busy ? 6'd0 : (c_DECK_SIZE - r_ptr);
    assign cards_updated   = r_cards_updated;
    assign last_card       = r_last_card;
    assign p1_low          = r_low[0];
    assign p2_low          = r_low[1];
    assign d_low           = r_low[2];
    assign p1_high         = high_of(r_low[0], r_ace[0]);
    assign p2_high         = high_of(r_low[1], r_ace[1]);
    assign d_high          = high_of(r_low[2], r_ace[2]);

endmodule
`default_nettype wire

// File: tb/tb_deck_dealer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_deck_dealer
//  Description : Self-checking bench for deck_dealer. Table-driven draws plus
//                hand-written sequences for empty-shoe refill, new_game and
//                reset during DEAL. Hand totals are tracked by a scoreboard
//                fed with the dealt card codes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_deck_dealer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       new_game = 1'b0;
    logic [1:0] draw_sel = 2'd0;
    logic [4:0] p1_high, p1_low, p2_high, p2_low, d_high, d_low;
    logic       cards_updated, busy;
    logic [5:0] last_card, cards_remaining;

    deck_dealer #(.LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst_n(rst_n), .new_game(new_game), .draw_sel(draw_sel),
        .p1_high(p1_high), .p1_low(p1_low), .p2_high(p2_high), .p2_low(p2_low),
        .d_high(d_high), .d_low(d_low), .cards_updated(cards_updated), .busy(busy),
        .last_card(last_card), .cards_remaining(cards_remaining)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    int m_low [0:2];
    bit m_ace [0:2];
    int n_dealt;
    bit seen [0:63];
    int n_dup;
    int n_bad_rank;

    typedef struct {
        logic [1:0] sel;
        int         hold;
        int         exp_pulses;
        int         exp_lat;
    } vec_t;
    vec_t vecs [0:5];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_high(input int low, input bit ace);
        int s;
        s = low + (ace ? 10 : 0);
        return (s > 31) ? 31 : s;
    endfunction

    task automatic model_clear();
        for (int h = 0; h < 3; h++) begin
            m_low[h] = 0;
            m_ace[h] = 1'b0;
        end
    endtask

    task automatic model_update(input logic [1:0] sel);
        int r, v, h;
        r = int'(last_card[3:0]);
        if (r < 1 || r > 13) n_bad_rank++;
        v = (r >= 10) ? 10 : r;
        h = int'(sel) - 1;
        m_low[h] = (m_low[h] + v > 31) ? 31 : m_low[h] + v;
        if (r == 1) m_ace[h] = 1'b1;
    endtask

    task automatic cmp_hands(input string tag);
        chk({tag, ":p1_low"},  int'(p1_low),  m_low[0]);
        chk({tag, ":p1_high"}, int'(p1_high), exp_high(m_low[0], m_ace[0]));
        chk({tag, ":p2_low"},  int'(p2_low),  m_low[1]);
        chk({tag, ":p2_high"}, int'(p2_high), exp_high(m_low[1], m_ace[1]));
        chk({tag, ":d_low"},   int'(d_low),   m_low[2]);
        chk({tag, ":d_high"},  int'(d_high),  exp_high(m_low[2], m_ace[2]));
    endtask

    // Holds draw_sel for 'hold' clock edges, then watches until the block
    // is back in READY. Reports pulse count and sample index of first pulse.
    task automatic do_draw(input logic [1:0] sel, input int hold,
                           output int npulse, output int lat);
        @(negedge clk);
        draw_sel = sel;
        npulse = 0;
        lat = -1;
        for (int k = 1; k <= hold + 4; k++) begin
            @(negedge clk);
            if (cards_updated) begin
                npulse++;
                if (lat < 0) lat = k;
                if (n_dealt < 52) begin
                    if (seen[last_card]) n_dup++;
                    seen[last_card] = 1'b1;
                end
                n_dealt++;
                model_update(sel);
            end
            if (k == hold) draw_sel = 2'd0;
        end
    endtask

    // Holds a request through a busy period and returns the pulse latency
    // measured from the first sample where busy was low.
    task automatic held_draw(input logic [1:0] sel, output int got,
                             output int k_pulse, output int k_ready);
        int k;
        k = 0;
        got = 0;
        k_ready = -1;
        k_pulse = -1;
        draw_sel = sel;
        while (got == 0 && k < 4000) begin
            @(negedge clk);
            k++;
            if (k_ready < 0 && !busy) k_ready = k;
            if (cards_updated) begin
                got = 1;
                k_pulse = k;
                model_update(sel);
            end
        end
    endtask

    initial begin
        int np, lat, got, kp, kr, k, extra;

        vecs[0] = '{sel: 2'd1, hold: 4, exp_pulses: 1, exp_lat: 2};
        vecs[1] = '{sel: 2'd2, hold: 1, exp_pulses: 1, exp_lat: 2};
        vecs[2] = '{sel: 2'd3, hold: 2, exp_pulses: 1, exp_lat: 2};
        vecs[3] = '{sel: 2'd1, hold: 1, exp_pulses: 1, exp_lat: 2};
        vecs[4] = '{sel: 2'd3, hold: 3, exp_pulses: 1, exp_lat: 2};
        vecs[5] = '{sel: 2'd2, hold: 6, exp_pulses: 1, exp_lat: 2};

        model_clear();
        n_dealt = 0;
        n_dup = 0;
        n_bad_rank = 0;
        for (int i = 0; i < 64; i++) seen[i] = 1'b0;

        // ---------------- reset state ----------------
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 1);
        chk("rst_updated", int'(cards_updated), 0);
        chk("rst_last_card", int'(last_card), 0);
        chk("rst_remaining", int'(cards_remaining), 0);
        cmp_hands("rst");
        rst_n = 1'b1;

        // ---------------- initial fill/shuffle ----------------
        k = 0;
        while (busy && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("init_busy_fall", int'(busy), 0);
        chk("init_remaining", int'(cards_remaining), 52);

        // ---------------- table-driven draws ----------------
        for (int v = 0; v < 6; v++) begin
            do_draw(vecs[v].sel, vecs[v].hold, np, lat);
            chk($sformatf("vec%0d_pulses", v), np, vecs[v].exp_pulses);
            chk($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
            chk($sformatf("vec%0d_remaining", v), int'(cards_remaining), 52 - n_dealt);
            cmp_hands($sformatf("vec%0d", v));
        end

        // ---------------- rest of the shoe to the dealer ----------------
        while (n_dealt < 52) begin
            do_draw(2'd3, 1, np, lat);
            chk("dealer_pulses", np, 1);
            cmp_hands("dealer");
        end
        chk("dealer_low_saturated", int'(d_low), 31);
        chk("deck_empty_remaining", int'(cards_remaining), 0);
        chk("deck_duplicates", n_dup, 0);
        chk("deck_bad_rank", n_bad_rank, 0);

        // ---------------- 53rd request: refill then serve ----------------
        @(negedge clk);
        draw_sel = 2'd1;
        @(negedge clk);
        chk("empty_busy_rise", int'(busy), 1);
        chk("empty_remaining_busy", int'(cards_remaining), 0);
        held_draw(2'd1, got, kp, kr);
        chk("refill_served", got, 1);
        chk("refill_latency", kp, kr + 2);
        chk("refill_remaining", int'(cards_remaining), 51);
        cmp_hands("refill");
        draw_sel = 2'd0;
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (cards_updated) extra++;
        end
        chk("refill_extra_pulses", extra, 0);

        // ---------------- new_game with same-cycle draw, and mid-shuffle --------
        @(negedge clk);
        new_game = 1'b1;
        draw_sel = 2'd2;
        @(negedge clk);
        new_game = 1'b0;
        model_clear();
        chk("ng_busy", int'(busy), 1);
        chk("ng_last_card", int'(last_card), 0);
        chk("ng_updated", int'(cards_updated), 0);
        cmp_hands("ng");
        extra = 0;
        repeat (60) begin
            @(negedge clk);
            if (cards_updated) extra++;
        end
        chk("ng_midshuffle_busy", int'(busy), 1);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        chk("ng2_busy", int'(busy), 1);
        chk("ng2_remaining", int'(cards_remaining), 0);
        held_draw(2'd2, got, kp, kr);
        chk("ng_served", got, 1);
        chk("ng_latency", kp, kr + 2);
        chk("ng_remaining", int'(cards_remaining), 51);
        cmp_hands("ng_served");
        draw_sel = 2'd0;
        repeat (4) begin
            @(negedge clk);
            if (cards_updated) extra++;
        end
        chk("ng_extra_pulses", extra, 0);

        // ---------------- reset in the DEAL cycle ----------------
        @(negedge clk);
        draw_sel = 2'd3;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("dealrst_updated", int'(cards_updated), 0);
        chk("dealrst_busy", int'(busy), 1);
        chk("dealrst_last_card", int'(last_card), 0);
        chk("dealrst_remaining", int'(cards_remaining), 0);
        cmp_hands("dealrst");
        @(negedge clk);
        draw_sel = 2'd0;
        @(negedge clk);
        chk("dealrst_no_pulse", int'(cards_updated), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("dealrst_release_busy", int'(busy), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
